// File: rtl/chacha_block_ctrl.sv
// ChaCha block-function sequencer: one shared combinational quarter-round,
// one QR step per clock, feed-forward add, valid/ready keystream output.

module chacha_qr (
    input  logic [31:0] a_in,
    input  logic [31:0] b_in,
    input  logic [31:0] c_in,
    input  logic [31:0] d_in,
    output logic [31:0] a_out,
    output logic [31:0] b_out,
    output logic [31:0] c_out,
    output logic [31:0] d_out
);
    logic [31:0] a1, b1, c1, d1, a2, b2, c2, d2;

    always_comb begin
        a1 = a_in + b_in;
        d1 = d_in ^ a1;
        d1 = {d1[15:0], d1[31:16]};
        c1 = c_in + d1;
        b1 = b_in ^ c1;
        b1 = {b1[19:0], b1[31:20]};
        a2 = a1 + b1;
        d2 = d1 ^ a2;
        d2 = {d2[23:0], d2[31:24]};
        c2 = c1 + d2;
        b2 = b1 ^ c2;
        b2 = {b2[24:0], b2[31:25]};
        a_out = a2;
        b_out = b2;
        c_out = c2;
        d_out = d2;
    end
endmodule

// state | meaning
// IDLE  | waiting for start; start_ready=1
// ROUND | one quarter-round per cycle, qi selects column/diagonal step
// FINAL | feed-forward add into block_out, register counter_next
// DONE  | out_valid held until out_ready
module chacha_block_ctrl #(
    parameter int NUM_DOUBLE_ROUNDS = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    output logic         start_ready,
    input  logic [255:0] key,
    input  logic [31:0]  counter,
    input  logic [95:0]  nonce,
    output logic         busy,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [511:0] block_out,
    output logic [31:0]  counter_next
);
    typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;

    localparam logic [3:0] LAST_DR = 4'(NUM_DOUBLE_ROUNDS - 1);

    state_t      state_q, state_d;
    logic [31:0] work_q [16];
    logic [31:0] init_q [16];
    logic [31:0] load_w [16];
    logic [2:0]  qi_q;
    logic [3:0]  dr_q;
    logic [3:0]  ia, ib, ic, id;
    logic [31:0] qa, qb, qc, qd;
    logic        last_step;

    assign start_ready = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign out_valid   = (state_q == DONE);
    assign last_step   = (qi_q == 3'd7) && (dr_q == LAST_DR);

    // Diagonal steps rotate rows 1..3 by 1..3 columns relative to row 0.
    always_comb begin
        ia = {2'b00, qi_q[1:0]};
        ib = {2'b01, qi_q[1:0] + {1'b0, qi_q[2]}};
        ic = {2'b10, qi_q[1:0] + {qi_q[2], 1'b0}};
        id = {2'b11, qi_q[1:0] + {qi_q[2], qi_q[2]}};
    end

    always_comb begin
        for (int i = 0; i < 16; i++) load_w[i] = '0;
        load_w[0] = 32'h61707865;
        load_w[1] = 32'h3320646e;
        load_w[2] = 32'h79622d32;
        load_w[3] = 32'h6b206574;
        for (int i = 0; i < 8; i++) load_w[4 + i] = key[32*i +: 32];
        load_w[12] = counter;
        for (int i = 0; i < 3; i++) load_w[13 + i] = nonce[32*i +: 32];
    end

    chacha_qr u_qr (
        .a_in  (work_q[ia]),
        .b_in  (work_q[ib]),
        .c_in  (work_q[ic]),
        .d_in  (work_q[id]),
        .a_out (qa),
        .b_out (qb),
        .c_out (qc),
        .d_out (qd)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = ROUND;
            ROUND:   if (last_step) state_d = FINAL;
            FINAL:   state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                work_q[i] <= '0;
                init_q[i] <= '0;
            end
            qi_q         <= '0;
            dr_q         <= '0;
            block_out    <= '0;
            counter_next <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        for (int i = 0; i < 16; i++) begin
                            work_q[i] <= load_w[i];
                            init_q[i] <= load_w[i];
                        end
                        qi_q <= '0;
                        dr_q <= '0;
                    end
                end
                ROUND: begin
                    work_q[ia] <= qa;
                    work_q[ib] <= qb;
                    work_q[ic] <= qc;
                    work_q[id] <= qd;
                    qi_q       <= qi_q + 3'd1;
                    if (qi_q == 3'd7) dr_q <= dr_q + 4'd1;
                end
                FINAL: begin
                    for (int i = 0; i < 16; i++)
                        block_out[32*i +: 32] <= work_q[i] + init_q[i];
                    counter_next <= init_q[12] + 32'd1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/chacha_block_ctrl.md
Name: chacha_block_ctrl

Overview:
- Sequences one shared instance of the combinational QR quarter-round module to compute one ChaCha20 keystream block (RFC 8439 block function).
- Loads constants, key, block counter and nonce into a 16-word working state, then runs one QR per cycle across column and diagonal rounds.
- Applies the feed-forward add and presents a 512-bit keystream block through a valid/ready handshake.
- Sits between the RNG seed/reseed logic and the keystream consumer.

Parameters:
- NUM_DOUBLE_ROUNDS, 10, number of double rounds (10 = ChaCha20; 4 and 6 give ChaCha8 and ChaCha12); legal range 1..15.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request a block; accepted only when start_ready=1
- start_ready  output  1  high in IDLE only
- key  input  256  key; key[32*i+31:32*i] loads state word 4+i
- counter  input  32  block counter; loads state word 12
- nonce  input  96  nonce; nonce[32*i+31:32*i] loads state word 13+i
- busy  output  1  high from the accept edge until the output handshake completes
- out_valid  output  1  keystream block available
- out_ready  input  1  consumer accepts the block
- block_out  output  512  keystream; block_out[32*i+31:32*i] = word i
- counter_next  output  32  captured counter + 1, mod 2^32; valid while out_valid=1

Behaviour:
- Reset, asynchronous on rst_n=0: FSM goes to IDLE; all state registers, the input copy, the round counter, block_out and counter_next clear to 0; out_valid=0, busy=0, start_ready=1.
- Reset mid-operation: abandons the block with no output; all registers clear as above.
- FSM states: IDLE, ROUND, FINAL, DONE.
- IDLE: start_ready=1. On start=1, at the same edge:
  - working state and input copy load {0x61707865, 0x3320646e, 0x79622d32, 0x6b206574, key words, counter, nonce words};
  - step counter qi clears to 0 and double-round counter clears to 0;
  - FSM goes to ROUND.
- start while not IDLE: ignored, with no effect on the block in progress.
- ROUND: each cycle, feed the 4 words selected by qi to QR and write the 4 results back at the same edge.
  - Column steps: qi=0 (0,4,8,12), 1 (1,5,9,13), 2 (2,6,10,14), 3 (3,7,11,15).
  - Diagonal steps: qi=4 (0,5,10,15), 5 (1,6,11,12), 6 (2,7,8,13), 7 (3,4,9,14).
  - QR operand order is a_in..d_in = the listed words in order.
  - qi is 3 bits and wraps 7->0; the double-round counter increments on each wrap.
  - After step 7 of the last double round, FSM goes to FINAL.
- FINAL, one cycle: block_out word i = working word i + input word i, mod 2^32 with no carry between words. At the same edge, counter_next is registered, out_valid is set and FSM goes to DONE.
- DONE: block_out, counter_next and out_valid hold stable until out_valid & out_ready.
  - On that handshake, go to IDLE with out_valid=0; block_out keeps its last value.
  - A start in the handshake cycle is not accepted; it is accepted one cycle later in IDLE.
- Latency: out_valid rises exactly 8*NUM_DOUBLE_ROUNDS+1 clocks after the accepting edge (81 for the default).
- key, counter and nonce may change freely after the accepting edge; only the captured copies are used.
- Counter wrap: counter=0xFFFFFFFF gives counter_next=0x00000000 with no flag.
- The working state is never visible on outputs before FINAL.

Test Plan:
- Reset then idle: rst_n low mid-ROUND for 2 cycles -> out_valid=0, busy=0, start_ready=1, block_out=0; no out_valid pulse afterwards without a new start.
- Zero vector: key=0, nonce=0, counter=0 -> block_out word0=0xade0b876, word1=0x903df1a0; out_valid exactly 81 cycles after accept; counter_next=1.
- RFC 8439 sec 2.3.2 vector: key bytes 00..1f (word4=0x03020100), nonce bytes 00 00 00 09 00 00 00 4a 00 00 00 00, counter=1 -> words 0..3 = 0xe4e7f110, 0x15593bd1, 0x1fdd0f50, 0xc47120a3; all 16 words match the RFC.
- Backpressure: hold out_ready=0 for 50 cycles with start pulsing -> block_out and out_valid stable, start_ready=0; release -> one handshake, then the next start is accepted one cycle later.
- Input churn and wrap: change key/nonce every cycle after accept, counter=0xFFFFFFFF -> output matches the captured inputs; counter_next=0.
- NUM_DOUBLE_ROUNDS=4 build: latency is 33 cycles; output matches a ChaCha8 reference model.
